// File: rtl/fpu_test_sequencer_if.sv
// Operand/result bus between the test sequencer (master) and the FPU under test (slave).
interface fpu_test_sequencer_if;
   logic        fpu_rst_n;
   logic [31:0] op_A_out;
   logic [31:0] op_B_out;
   logic [3:0]  fpu_status_in;
   logic [31:0] fpu_data_in;

   modport master (
      output fpu_rst_n, op_A_out, op_B_out,
      input  fpu_status_in, fpu_data_in
   );

   modport slave (
      input  fpu_rst_n, op_A_out, op_B_out,
      output fpu_status_in, fpu_data_in
   );
endinterface

// File: rtl/fpu_test_sequencer.sv
// Replays a table of operand pairs into an FPU, resetting it before each vector, and captures
// and classifies each result (or forces one on timeout).
module fpu_test_sequencer #(
   parameter int unsigned N_VEC   = 8,
   parameter int unsigned TIMEOUT = 64,
   localparam int unsigned IDX_W  = $clog2(N_VEC)
) (
   input  logic                 clock_100KHz,
   input  logic                 reset,
   input  logic                 vec_we,
   input  logic [IDX_W-1:0]     vec_addr,
   input  logic [31:0]          vec_a,
   input  logic [31:0]          vec_b,
   input  logic                 start,
   fpu_test_sequencer_if.master fpu,
   output logic                 busy,
   output logic                 done,
   output logic                 res_valid,
   output logic [31:0]          res_data,
   output logic [3:0]           res_status,
   output logic [IDX_W-1:0]     res_idx,
   output logic                 res_timeout,
   output logic [7:0]           cnt_exact,
   output logic [7:0]           cnt_ovf,
   output logic [7:0]           cnt_unf,
   output logic [7:0]           cnt_inx,
   output logic [7:0]           cnt_tmo
);

   typedef enum logic [2:0] {StIdle, StFpuRst, StDrive, StWait, StCapture, StDone} state_e;

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       wait_q;
   logic             rst_cnt_q;
   logic [31:0]      tbl_a [N_VEC];
   logic [31:0]      tbl_b [N_VEC];

   function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
      return (en && v != 8'hFF) ? v + 8'd1 : v;
   endfunction

   // Table is deliberately outside the reset domain so reset keeps loaded vectors.
   always_ff @(posedge clock_100KHz) begin
      if (vec_we && state_q == StIdle) begin
         tbl_a[vec_addr] <= vec_a;
         tbl_b[vec_addr] <= vec_b;
      end
   end

   always_ff @(posedge clock_100KHz) begin
      if (reset) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         wait_q        <= '0;
         rst_cnt_q     <= 1'b0;
         fpu.fpu_rst_n <= 1'b0;
         fpu.op_A_out  <= '0;
         fpu.op_B_out  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_status    <= '0;
         res_idx       <= '0;
         res_timeout   <= 1'b0;
         cnt_exact     <= '0;
         cnt_ovf       <= '0;
         cnt_unf       <= '0;
         cnt_inx       <= '0;
         cnt_tmo       <= '0;
      end else begin
         done      <= 1'b0;
         res_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               fpu.fpu_rst_n <= 1'b1;
               if (start) begin
                  idx_q         <= '0;
                  wait_q        <= '0;
                  rst_cnt_q     <= 1'b0;
                  cnt_exact     <= '0;
                  cnt_ovf       <= '0;
                  cnt_unf       <= '0;
                  cnt_inx       <= '0;
                  cnt_tmo       <= '0;
                  busy          <= 1'b1;
                  fpu.fpu_rst_n <= 1'b0;
                  fpu.op_A_out  <= '0;
                  fpu.op_B_out  <= '0;
                  state_q       <= StFpuRst;
               end
            end
            StFpuRst: begin
               if (rst_cnt_q) begin
                  fpu.fpu_rst_n <= 1'b1;
                  fpu.op_A_out  <= tbl_a[idx_q];
                  fpu.op_B_out  <= tbl_b[idx_q];
                  state_q       <= StDrive;
               end else begin
                  rst_cnt_q <= 1'b1;
               end
            end
            StDrive: begin
               wait_q  <= '0;
               state_q <= StWait;
            end
            StWait: begin
               wait_q <= wait_q + 8'd1;
               // A real status on the last allowed cycle beats the timeout.
               if (fpu.fpu_status_in != 4'b0 || wait_q == 8'(TIMEOUT - 1)) begin
                  res_data    <= fpu.fpu_data_in;
                  res_status  <= fpu.fpu_status_in;
                  res_idx     <= idx_q;
                  res_timeout <= (fpu.fpu_status_in == 4'b0);
                  res_valid   <= 1'b1;
                  state_q     <= StCapture;
               end
            end
            StCapture: begin
               cnt_exact <= sat_inc(cnt_exact, res_status[0]);
               cnt_ovf   <= sat_inc(cnt_ovf, res_status[1]);
               cnt_unf   <= sat_inc(cnt_unf, res_status[2]);
               cnt_inx   <= sat_inc(cnt_inx, res_status[3]);
               cnt_tmo   <= sat_inc(cnt_tmo, res_timeout);
               if (idx_q == IDX_W'(N_VEC - 1)) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  idx_q         <= idx_q + 1'b1;
                  rst_cnt_q     <= 1'b0;
                  fpu.fpu_rst_n <= 1'b0;
                  fpu.op_A_out  <= '0;
                  fpu.op_B_out  <= '0;
                  state_q       <= StFpuRst;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_test_sequencer.sv
// Scoreboard bench: each run pushes per-vector expectations; a forked monitor checks res_valid.
module tb_fpu_test_sequencer;
   localparam int N  = 8;
   localparam int TO = 64;

   logic        clock_100KHz = 1'b0;
   logic        reset = 1'b1;
   logic        vec_we = 1'b0;
   logic [2:0]  vec_addr = '0;
   logic [31:0] vec_a = '0;
   logic [31:0] vec_b = '0;
   logic        start = 1'b0;
   logic        busy, done, res_valid, res_timeout;
   logic [31:0] res_data;
   logic [3:0]  res_status;
   logic [2:0]  res_idx;
   logic [7:0]  cnt_exact, cnt_ovf, cnt_unf, cnt_inx, cnt_tmo;

   logic [3:0]  fpu_code = 4'b0;
   int          fpu_delay = 0;
   int          cyc = 0;

   logic [31:0] tbl_a [N];
   logic [31:0] tbl_b [N];

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic [3:0]  st;
      logic        tmo;
      int          w;
   } exp_t;
   exp_t exp_q [$];

   int n_tests = 0;
   int n_fail  = 0;

   fpu_test_sequencer_if fpu_if ();

   fpu_test_sequencer #(.N_VEC(N), .TIMEOUT(TO)) dut (
      .clock_100KHz (clock_100KHz),
      .reset        (reset),
      .vec_we       (vec_we),
      .vec_addr     (vec_addr),
      .vec_a        (vec_a),
      .vec_b        (vec_b),
      .start        (start),
      .fpu          (fpu_if),
      .busy         (busy),
      .done         (done),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .res_status   (res_status),
      .res_idx      (res_idx),
      .res_timeout  (res_timeout),
      .cnt_exact    (cnt_exact),
      .cnt_ovf      (cnt_ovf),
      .cnt_unf      (cnt_unf),
      .cnt_inx      (cnt_inx),
      .cnt_tmo      (cnt_tmo)
   );

   always #5 clock_100KHz = ~clock_100KHz;

   // FPU model: cycles since fpu_rst_n rose; DRIVE sees 0, WAIT cycle k sees k.
   always @(posedge clock_100KHz) begin
      if (!fpu_if.fpu_rst_n) cyc <= 0;
      else if (cyc < 1000)   cyc <= cyc + 1;
   end
   assign fpu_if.fpu_status_in = (fpu_if.fpu_rst_n && fpu_delay != 0 && cyc >= fpu_delay)
                                 ? fpu_code : 4'b0;
   assign fpu_if.fpu_data_in   = fpu_if.op_A_out + fpu_if.op_B_out;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   task automatic do_run(input logic [3:0] code, input int dly, input int poke_at,
                         input int abort_at);
      logic tmo;
      int   w, n, n_exp, done_at;
      logic got_done;
      tmo     = (dly == 0 || dly > TO);
      w       = tmo ? TO : dly;
      done_at = N * (4 + w) + 1;
      n_exp   = N;
      if (abort_at != 0) begin
         n_exp = 0;
         for (int k = 0; k < N; k++) if ((k + 1) * (4 + w) <= abort_at) n_exp = k + 1;
      end
      for (int i = 0; i < n_exp; i++) begin
         exp_q.push_back('{idx: i, data: tbl_a[i] + tbl_b[i], st: tmo ? 4'b0 : code,
                           tmo: tmo, w: w});
      end
      fpu_code  = code;
      fpu_delay = dly;
      start     = 1'b1;
      @(negedge clock_100KHz);
      start    = 1'b0;
      n        = 1;
      got_done = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("fpu_rst_n_in_fpu_rst", 32'(fpu_if.fpu_rst_n), 32'd0);
      chk("op_a_in_fpu_rst", fpu_if.op_A_out, 32'd0);
      while (n <= 2000 && !got_done) begin
         if (n == 3) begin
            chk("fpu_rst_n_in_drive", 32'(fpu_if.fpu_rst_n), 32'd1);
            chk("op_b_in_drive", fpu_if.op_B_out, tbl_b[0]);
         end
         if (done) begin
            got_done = 1'b1;
         end else begin
            if (n == abort_at) begin
               reset = 1'b1;
               @(negedge clock_100KHz);
               reset = 1'b0;
               chk("abort_busy", 32'(busy), 32'd0);
               chk("abort_fpu_rst_n", 32'(fpu_if.fpu_rst_n), 32'd0);
               chk("abort_cnt_tmo", 32'(cnt_tmo), 32'd0);
               chk("abort_cnt_exact", 32'(cnt_exact), 32'd0);
               chk("abort_res_valid", 32'(res_valid), 32'd0);
               chk("abort_pending_results", 32'(exp_q.size()), 32'd0);
               exp_q.delete();
               @(negedge clock_100KHz);
               return;
            end
            if (n == poke_at) begin
               vec_we   = 1'b1;
               vec_addr = 3'd2;
               vec_a    = 32'hDEAD_BEEF;
               vec_b    = 32'h0BAD_F00D;
               start    = 1'b1;
            end
            @(negedge clock_100KHz);
            vec_we = 1'b0;
            start  = 1'b0;
            n++;
         end
      end
      if (!got_done) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: no done within 2000 cycles, expected at cycle %0d", done_at);
      end else begin
         chk("done_cycle", 32'(n), 32'(done_at));
         chk("busy_at_done", 32'(busy), 32'd0);
         chk("cnt_exact", 32'(cnt_exact), (!tmo && code[0]) ? 32'(N) : 32'd0);
         chk("cnt_ovf",   32'(cnt_ovf),   (!tmo && code[1]) ? 32'(N) : 32'd0);
         chk("cnt_unf",   32'(cnt_unf),   (!tmo && code[2]) ? 32'(N) : 32'd0);
         chk("cnt_inx",   32'(cnt_inx),   (!tmo && code[3]) ? 32'(N) : 32'd0);
         chk("cnt_tmo",   32'(cnt_tmo),   tmo ? 32'(N) : 32'd0);
         chk("pending_results", 32'(exp_q.size()), 32'd0);
      end
      @(negedge clock_100KHz);
      chk("done_is_pulse", 32'(done), 32'd0);
      chk("res_idx_holds", 32'(res_idx), 32'(N - 1));
   endtask

   initial begin
      tbl_a = '{32'h3F80_0000, 32'h4000_0000, 32'h1234_5678, 32'h8000_0001,
                32'h7FFF_FFFF, 32'h0000_0010, 32'hC0A0_0000, 32'h5555_AAAA};
      tbl_b = '{32'h0000_0001, 32'h4040_0000, 32'h1111_1111, 32'h0000_00FF,
                32'h0000_0001, 32'h0000_0020, 32'h4120_0000, 32'hAAAA_5555};

      fork
         forever begin
            exp_t e;
            @(negedge clock_100KHz);
            if (res_valid) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_res_valid: got idx %0d, expected no result", res_idx);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_idx", 32'(res_idx), 32'(e.idx));
                  chk("res_data", res_data, e.data);
                  chk("res_status", 32'(res_status), 32'(e.st));
                  chk("res_timeout", 32'(res_timeout), 32'(e.tmo));
                  chk("capture_latency", 32'(cyc), 32'(e.w + 1));
                  chk("op_a_held", fpu_if.op_A_out, tbl_a[e.idx]);
               end
            end
         end
      join_none

      repeat (2) @(negedge clock_100KHz);
      chk("rst_fpu_rst_n", 32'(fpu_if.fpu_rst_n), 32'd0);
      chk("rst_op_a", fpu_if.op_A_out, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_status", 32'(res_status), 32'd0);
      chk("rst_cnt_tmo", 32'(cnt_tmo), 32'd0);
      reset = 1'b0;
      @(negedge clock_100KHz);
      chk("fpu_rst_n_release", 32'(fpu_if.fpu_rst_n), 32'd1);

      for (int i = 0; i < N; i++) begin
         vec_we   = 1'b1;
         vec_addr = 3'(i);
         vec_a    = tbl_a[i];
         vec_b    = tbl_b[i];
         @(negedge clock_100KHz);
      end
      vec_we = 1'b0;

      do_run(4'b0001, 3, 0, 0);    // nominal exact results, 7 cycles per vector
      do_run(4'b0001, 0, 0, 0);    // silent FPU, every vector times out
      do_run(4'b1010, 2, 0, 0);    // overflow + inexact together
      do_run(4'b0001, 3, 5, 0);    // vec_we/start mid-run are ignored
      do_run(4'b0001, TO, 0, 0);   // status on the final timeout cycle wins
      do_run(4'b0000, 0, 0, 220);  // reset during WAIT of vector 3
      do_run(4'b0100, 5, 0, 0);    // fresh run starts from idx 0

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
